// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
//   Packet-level round-robin arbiter that merges N_PORTS input FIFOs onto one
//   output link. Once a head flit wins, the port keeps the output until its
//   tail flit is handed downstream. Flits pass through combinationally, so
//   nothing is buffered inside this block.
//
// Ports
//   i_clk        single clock, rising edge
//   i_arst_n     asynchronous active-low reset
//   i_data       N_PORTS x WIDTH flits, one from each input FIFO
//   i_valid      per-port flit valid
//   o_ready      per-port ready back to the input FIFO read ports
//   o_data       flit of the selected port
//   o_valid      output flit valid
//   i_ready      downstream ready
//   o_grant      one-hot packet owner, zero while idle
//   o_pkt_count  packets forwarded since reset, saturating at 16'hFFFF
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no owner; round-robin pick among valid ports from rr_ptr
// BUSY  | owner latched; only the owner's flits pass until its tail
module noc_output_arbiter #(
   parameter int WIDTH    = 73,
   parameter int N_PORTS  = 4,
   parameter int TAIL_BIT = 72
) (
   input  logic                             i_clk,
   input  logic                             i_arst_n,
   input  logic [N_PORTS-1:0][WIDTH-1:0]    i_data,
   input  logic [N_PORTS-1:0]               i_valid,
   output logic [N_PORTS-1:0]               o_ready,
   output logic [WIDTH-1:0]                 o_data,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic [N_PORTS-1:0]               o_grant,
   output logic [15:0]                      o_pkt_count
);

   localparam int PTR_W = $clog2(N_PORTS);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   owner;
   logic [PTR_W-1:0]   winner;
   logic [PTR_W-1:0]   sel;
   logic [N_PORTS-1:0] grant_q;
   logic [15:0]        pkt_count;
   logic               hs;
   logic               tail;

   // Modulo add that stays correct for non-power-of-two port counts.
   function automatic logic [PTR_W-1:0] rr_add(input logic [PTR_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_PORTS) s = s - N_PORTS;
      return PTR_W'(s);
   endfunction

   // Scan from the farthest candidate back to rr_ptr so the last match,
   // i.e. the first valid port at or after rr_ptr, is the one kept.
   always_comb begin
      winner = rr_ptr;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
         if (i_valid[rr_add(rr_ptr, k)]) winner = rr_add(rr_ptr, k);
      end
   end

   assign sel     = (state == BUSY) ? owner : winner;
   assign o_valid = (state == BUSY) ? i_valid[owner] : |i_valid;
   assign o_data  = i_data[sel];

   always_comb begin
      o_ready      = '0;
      o_ready[sel] = i_ready;
   end

   assign hs          = o_valid & i_ready;
   assign tail        = o_data[TAIL_BIT];
   assign o_grant     = grant_q;
   assign o_pkt_count = pkt_count;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         grant_q   <= '0;
         pkt_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hs && tail) begin
                  rr_ptr <= rr_add(winner, 1);
                  if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
               end else if (o_valid) begin
                  // Lock the winner even without a handshake so the offered
                  // flit can never be swapped for another port's flit.
                  state   <= BUSY;
                  owner   <= winner;
                  grant_q <= N_PORTS'(1) << winner;
               end
            end
            BUSY: begin
               if (hs && tail) begin
                  state   <= IDLE;
                  rr_ptr  <= rr_add(owner, 1);
                  grant_q <= '0;
                  if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule
